usb_tx_packetizer: RTL and testbench
====================================

# usb_tx_packetizer

Parametrised byte-level USB transmit packetizer for the USB TX path. It builds SYNC, PID, payload, CRC16 and end-of-packet sequences for DATA0/DATA1/ACK/NAK/STALL packets. It pulls payload from a first-word-fall-through FIFO and hands bytes to the downstream NRZI/bit-stuff serializer over a valid/ready handshake. It computes CRC16 internally and flags payload underrun.

## Interface

Parameters:
- MAX_PAYLOAD, 64: largest legal payload in bytes.
- SIZE_W, $clog2(MAX_PAYLOAD+1): width of `tx_size` and of the internal remaining-byte counter.
- SYNC_BYTE, 8'h80: SYNC pattern sent first.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  reset. One clock domain; reset is asynchronous and active-high.
- tx_start  in  1  request. Sampled only in IDLE.
- tx_type  in  3  packet type: 0=DATA0, 1=DATA1, 2=ACK, 3=NAK, 4=STALL, 5–7=illegal.
- tx_size  in  SIZE_W  payload bytes. Latched at start; ignored for handshake types.
- fifo_data  in  8  FIFO head byte, valid when `fifo_empty`=0.
- fifo_empty  in  1  FIFO has no byte.
- fifo_rd  out  1  pop FIFO head. Combinational.
- byte_out  out  8  byte to serializer. Registered.
- byte_valid  out  1  `byte_out` valid. Registered.
- byte_ready  in  1  serializer accepts `byte_out` this cycle.
- eop_req  out  1  request EOP from serializer. Level signal.
- eop_done  in  1  serializer finished EOP. Single-cycle pulse.
- tx_busy  out  1  state ≠ IDLE.
- tx_done  out  1  one-cycle pulse when the packet completes.
- tx_error  out  1  one-cycle pulse: illegal request or underrun.

## Operation

- States: IDLE, SYNC, PID, DATA, CRC_LO, CRC_HI, EOP, DONE.
- Byte transfer occurs on any cycle with `byte_valid`=1 and `byte_ready`=1.
  - `byte_out` is held stable while `byte_valid`=1 and `byte_ready`=0.
  - The next byte is loaded on the acceptance edge, so `byte_valid` may stay high back-to-back with no bubbles.
- IDLE, on `tx_start`=1:
  - If `tx_type`>4, or `tx_type`≤1 and `tx_size`>MAX_PAYLOAD: pulse `tx_error`, stay in IDLE.
  - Otherwise: latch the type and size, set CRC to 16'hFFFF, load `byte_out`=SYNC_BYTE, set `byte_valid`=1, go to SYNC.
- SYNC, on accept: load the PID byte and go to PID.
  - PID bytes: DATA0=8'hC3, DATA1=8'h4B, ACK=8'hD2, NAK=8'h5A, STALL=8'h1E.
- PID, on accept, next state depends on type and size:
  - Handshake type: `byte_valid`→0, go to EOP.
  - Data type with size 0: load ~crc[7:0], go to CRC_LO.
  - Data type with size>0: load the first payload byte, go to DATA.
- Payload load (from PID or DATA):
  - If `fifo_empty`=0: `fifo_rd`=1 in the accepting cycle, `byte_out`←`fifo_data`, CRC updated with that byte, remaining count decremented.
  - If `fifo_empty`=1: underrun. Pulse `tx_error`, `byte_valid`→0, go to EOP. The packet is truncated and the receiver sees a bad CRC.
- DATA, on accept:
  - Remaining>0: perform the next payload load.
  - Remaining=0: load ~crc[7:0], go to CRC_LO.
- CRC_LO, on accept: load ~crc[15:8], go to CRC_HI.
- CRC_HI, on accept: `byte_valid`→0, go to EOP.
- CRC16 rules:
  - Polynomial x^16+x^15+x^2+1.
  - Computed reflected (LSB-first, constant 16'hA001) over payload bytes only; init 16'hFFFF.
  - Transmitted inverted, low byte first.
  - The update for one whole byte completes in a single cycle.
- EOP: `eop_req`=1 until the cycle `eop_done`=1, then go to DONE.
- DONE: `tx_done`=1 for one cycle, then IDLE.
- `tx_start` is ignored in every state other than IDLE.
- `fifo_rd` is never asserted outside a payload load, and never while `fifo_empty`=1.

## Timing

- Reset values: state IDLE, CRC 16'hFFFF, counter 0.
  - All outputs 0: `byte_out`=8'h00, `byte_valid`, `eop_req`, `tx_busy`, `tx_done`, `tx_error`, `fifo_rd`.
- Reset asserted mid-packet aborts immediately. No EOP is requested and no `tx_done` is issued.
- Latency: `tx_start` at cycle 0 → `byte_valid`=1 with SYNC at cycle 1.
- With `byte_ready` held at 1, a size-N data packet presents bytes on cycles 1…N+4 (SYNC, PID, N payload, 2 CRC), then:
  - `eop_req` on cycle N+5.
  - With `eop_done` in the same cycle, `tx_done` on cycle N+6.
- A handshake packet presents 2 bytes on cycles 1–2, then `eop_req` on cycle 3.
- `tx_error` for an illegal request appears on cycle 1; `tx_busy` stays 0.
- `eop_done` outside EOP is ignored.

## Test plan

- Zero-length DATA0, `byte_ready`=1 → bytes 80, C3, 00, 00; `eop_req` on cycle 5; `tx_done` one cycle after `eop_done`; `fifo_rd` never asserted.
- DATA1 with 4 payload bytes 01 02 03 04 and random `byte_ready` stalls → bytes 80, 4B, 01, 02, 03, 04, then CRC bytes matching a bit-serial CRC16 model; `byte_out` stable during stalls; exactly 4 `fifo_rd` pulses.
- ACK, NAK, STALL in turn → bytes 80,D2 / 80,5A / 80,1E, each followed by EOP and `tx_done`; `tx_size`=MAX_PAYLOAD+5 ignored for these.
- `tx_type`=6, and DATA0 with `tx_size`=MAX_PAYLOAD+1 → `tx_error` pulse on cycle 1, `tx_busy` stays 0, no `byte_valid`.
- DATA0 size 3 with FIFO empty after 2 bytes → `tx_error` pulse, `byte_valid` drops, `eop_req` asserted, `tx_done` follows `eop_done`.
- `rst` asserted while in DATA, and `tx_start` pulsed while busy → all outputs 0 immediately after reset; a new packet then starts cleanly with CRC reinitialised; the mid-packet `tx_start` has no effect.

Source files
------------

// File: rtl/usb_tx_packetizer.sv
// Byte-level USB transmit packetizer: SYNC, PID, payload, CRC16 and EOP sequencing
// for DATA0/DATA1/ACK/NAK/STALL, with FWFT FIFO payload source and valid/ready output.
module usb_tx_packetizer #(
  parameter int unsigned MAX_PAYLOAD = 64,
  parameter int unsigned SIZE_W      = $clog2(MAX_PAYLOAD + 1),
  parameter logic [7:0]  SYNC_BYTE   = 8'h80
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tx_start,
  input  logic [2:0]        tx_type,
  input  logic [SIZE_W-1:0] tx_size,
  input  logic [7:0]        fifo_data,
  input  logic              fifo_empty,
  output logic              fifo_rd,
  output logic [7:0]        byte_out,
  output logic              byte_valid,
  input  logic              byte_ready,
  output logic              eop_req,
  input  logic              eop_done,
  output logic              tx_busy,
  output logic              tx_done,
  output logic              tx_error
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SYNC   = 3'd1;
  localparam logic [2:0] S_PID    = 3'd2;
  localparam logic [2:0] S_DATA   = 3'd3;
  localparam logic [2:0] S_CRC_LO = 3'd4;
  localparam logic [2:0] S_CRC_HI = 3'd5;
  localparam logic [2:0] S_EOP    = 3'd6;
  localparam logic [2:0] S_DONE   = 3'd7;

  localparam logic [15:0] CRC_INIT = 16'hFFFF;
  localparam logic [15:0] CRC_POLY = 16'hA001;

  // Reflected CRC16 update over one full byte in a single cycle.
  function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] data);
    logic [15:0] c;
    c = crc ^ {8'h00, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
    end
    return c;
  endfunction

  function automatic logic [7:0] pid_of(input logic [2:0] t);
    case (t)
      3'd0:    pid_of = 8'hC3;
      3'd1:    pid_of = 8'h4B;
      3'd2:    pid_of = 8'hD2;
      3'd3:    pid_of = 8'h5A;
      default: pid_of = 8'h1E;
    endcase
  endfunction

  logic [2:0]        state_q, state_d;
  logic [2:0]        type_q, type_d;
  logic [SIZE_W-1:0] cnt_q, cnt_d;
  logic [15:0]       crc_q, crc_d;
  logic [7:0]        byte_d;
  logic              valid_d;
  logic              error_d;
  logic              load;
  logic              accept;
  logic              is_data;
  logic              illegal;

  assign accept  = byte_valid & byte_ready;
  assign is_data = (type_q <= 3'd1);
  assign illegal = (tx_type > 3'd4) ||
                   ((tx_type <= 3'd1) && (tx_size > SIZE_W'(MAX_PAYLOAD)));

  // Next-state, next-output and FIFO pop decode.
  always_comb begin
    state_d = state_q;
    type_d  = type_q;
    cnt_d   = cnt_q;
    crc_d   = crc_q;
    byte_d  = byte_out;
    valid_d = byte_valid;
    error_d = 1'b0;
    fifo_rd = 1'b0;
    load    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (tx_start) begin
          if (illegal) begin
            error_d = 1'b1;
          end else begin
            type_d  = tx_type;
            cnt_d   = (tx_type <= 3'd1) ? tx_size : '0;
            crc_d   = CRC_INIT;
            byte_d  = SYNC_BYTE;
            valid_d = 1'b1;
            state_d = S_SYNC;
          end
        end
      end
      S_SYNC: begin
        if (accept) begin
          byte_d  = pid_of(type_q);
          state_d = S_PID;
        end
      end
      S_PID: begin
        if (accept) begin
          if (!is_data) begin
            valid_d = 1'b0;
            state_d = S_EOP;
          end else if (cnt_q == '0) begin
            byte_d  = ~crc_q[7:0];
            state_d = S_CRC_LO;
          end else begin
            load = 1'b1;
          end
        end
      end
      S_DATA: begin
        if (accept) begin
          if (cnt_q == '0) begin
            byte_d  = ~crc_q[7:0];
            state_d = S_CRC_LO;
          end else begin
            load = 1'b1;
          end
        end
      end
      S_CRC_LO: begin
        if (accept) begin
          byte_d  = ~crc_q[15:8];
          state_d = S_CRC_HI;
        end
      end
      S_CRC_HI: begin
        if (accept) begin
          valid_d = 1'b0;
          state_d = S_EOP;
        end
      end
      S_EOP: begin
        if (eop_done) state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // An empty FIFO at a payload load truncates the packet straight into EOP.
    if (load) begin
      if (!fifo_empty) begin
        fifo_rd = 1'b1;
        byte_d  = fifo_data;
        crc_d   = crc16_byte(crc_q, fifo_data);
        cnt_d   = cnt_q - SIZE_W'(1);
        state_d = S_DATA;
      end else begin
        error_d = 1'b1;
        valid_d = 1'b0;
        state_d = S_EOP;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      type_q     <= 3'd0;
      cnt_q      <= '0;
      crc_q      <= CRC_INIT;
      byte_out   <= 8'h00;
      byte_valid <= 1'b0;
      eop_req    <= 1'b0;
      tx_busy    <= 1'b0;
      tx_done    <= 1'b0;
      tx_error   <= 1'b0;
    end else begin
      state_q    <= state_d;
      type_q     <= type_d;
      cnt_q      <= cnt_d;
      crc_q      <= crc_d;
      byte_out   <= byte_d;
      byte_valid <= valid_d;
      eop_req    <= (state_d == S_EOP);
      tx_busy    <= (state_d != S_IDLE);
      tx_done    <= (state_d == S_DONE);
      tx_error   <= error_d;
    end
  end

endmodule

// File: tb/tb_usb_tx_packetizer.sv
// Directed self-checking bench for usb_tx_packetizer with a small FIFO model
// and a bit-serial CRC16 reference.
module tb_usb_tx_packetizer;

  localparam int unsigned MAX_PAYLOAD = 64;
  localparam int unsigned SIZE_W      = $clog2(MAX_PAYLOAD + 1);

  logic              clk = 1'b0;
  logic              rst;
  logic              tx_start;
  logic [2:0]        tx_type;
  logic [SIZE_W-1:0] tx_size;
  logic [7:0]        fifo_data;
  logic              fifo_empty;
  logic              fifo_rd;
  logic [7:0]        byte_out;
  logic              byte_valid;
  logic              byte_ready;
  logic              eop_req;
  logic              eop_done;
  logic              tx_busy;
  logic              tx_done;
  logic              tx_error;

  int vectors     = 0;
  int miscompares = 0;

  logic [7:0] mem [0:15];
  logic [4:0] rd_ptr = 5'd0;
  logic [4:0] wr_ptr = 5'd0;
  int         rd_count = 0;
  int         rd_empty_count = 0;

  assign fifo_empty = (rd_ptr == wr_ptr);
  assign fifo_data  = mem[rd_ptr[3:0]];

  always #5 clk = ~clk;

  usb_tx_packetizer #(.MAX_PAYLOAD(MAX_PAYLOAD), .SIZE_W(SIZE_W), .SYNC_BYTE(8'h80)) dut (
    .clk(clk), .rst(rst), .tx_start(tx_start), .tx_type(tx_type), .tx_size(tx_size),
    .fifo_data(fifo_data), .fifo_empty(fifo_empty), .fifo_rd(fifo_rd),
    .byte_out(byte_out), .byte_valid(byte_valid), .byte_ready(byte_ready),
    .eop_req(eop_req), .eop_done(eop_done), .tx_busy(tx_busy), .tx_done(tx_done),
    .tx_error(tx_error)
  );

  // FIFO model: pop on every fifo_rd edge, note any pop from an empty FIFO.
  always @(posedge clk) begin
    if (fifo_rd) begin
      rd_count <= rd_count + 1;
      if (fifo_empty) rd_empty_count <= rd_empty_count + 1;
      else rd_ptr <= rd_ptr + 5'd1;
    end
  end

  function automatic logic [15:0] crc_model(input logic [31:0] data, input int n);
    logic [15:0] crc;
    logic fb;
    crc = 16'hFFFF;
    for (int i = 0; i < n; i++) begin
      for (int j = 0; j < 8; j++) begin
        fb  = crc[0] ^ data[i*8 + j];
        crc = crc >> 1;
        if (fb) crc = crc ^ 16'hA001;
      end
    end
    return crc;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] b);
    mem[wr_ptr[3:0]] = b;
    wr_ptr = wr_ptr + 5'd1;
  endtask

  task automatic start(input logic [2:0] t, input logic [SIZE_W-1:0] s);
    tx_start = 1'b1;
    tx_type  = t;
    tx_size  = s;
    step();
    tx_start = 1'b0;
  endtask

  // Wait for one byte transfer; with stall set, byte_ready is randomised and
  // the held byte is checked on every stalled cycle.
  task automatic recv(input string tag, input logic [7:0] exp, input bit stall);
    int n;
    bit got;
    n   = 0;
    got = 1'b0;
    while (!got && n < 20) begin
      byte_ready = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
      if (byte_valid) begin
        chk(byte_ready ? tag : {tag, " held"}, byte_out, exp);
        if (byte_ready) got = 1'b1;
      end
      step();
      n++;
    end
    if (!got) chk({tag, " timeout"}, 32'(got), 32'd1);
  endtask

  task automatic finish_eop(input string tag);
    int n;
    n = 0;
    while (!eop_req && n < 10) begin
      step();
      n++;
    end
    chk({tag, " eop_req"}, eop_req, 1'b1);
    eop_done = 1'b1;
    step();
    eop_done = 1'b0;
    chk({tag, " tx_done"}, tx_done, 1'b1);
    chk({tag, " eop_req drop"}, eop_req, 1'b0);
    step();
    chk({tag, " tx_done pulse"}, tx_done, 1'b0);
    chk({tag, " idle"}, tx_busy, 1'b0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " byte_out"}, byte_out, 8'h00);
    chk({tag, " byte_valid"}, byte_valid, 1'b0);
    chk({tag, " eop_req"}, eop_req, 1'b0);
    chk({tag, " tx_busy"}, tx_busy, 1'b0);
    chk({tag, " tx_done"}, tx_done, 1'b0);
    chk({tag, " tx_error"}, tx_error, 1'b0);
    chk({tag, " fifo_rd"}, fifo_rd, 1'b0);
  endtask

  initial begin
    int base;
    logic [15:0] crc;
    logic [2:0]  hs_type [3];
    logic [7:0]  hs_pid  [3];

    rst        = 1'b1;
    tx_start   = 1'b0;
    tx_type    = 3'd0;
    tx_size    = '0;
    byte_ready = 1'b1;
    eop_done   = 1'b0;
    step();
    step();
    chk_all_zero("reset");
    rst = 1'b0;
    step();

    // Zero-length DATA0.
    base = rd_count;
    start(3'd0, '0);
    chk("d0 busy", tx_busy, 1'b1);
    recv("d0 sync", 8'h80, 1'b0);
    recv("d0 pid", 8'hC3, 1'b0);
    recv("d0 crc lo", 8'h00, 1'b0);
    recv("d0 crc hi", 8'h00, 1'b0);
    chk("d0 eop cyc5", eop_req, 1'b1);
    chk("d0 valid off", byte_valid, 1'b0);
    step();
    chk("d0 eop held", eop_req, 1'b1);
    finish_eop("d0");
    chk("d0 no fifo_rd", 32'(rd_count - base), 32'd0);

    // eop_done outside EOP.
    eop_done = 1'b1;
    step();
    eop_done = 1'b0;
    chk("stray eop_done busy", tx_busy, 1'b0);
    chk("stray eop_done done", tx_done, 1'b0);

    // DATA1 with 4 payload bytes and random stalls.
    base = rd_count;
    push(8'h01); push(8'h02); push(8'h03); push(8'h04);
    crc = crc_model(32'h04030201, 4);
    start(3'd1, SIZE_W'(4));
    recv("d1 sync", 8'h80, 1'b1);
    recv("d1 pid", 8'h4B, 1'b1);
    recv("d1 p0", 8'h01, 1'b1);
    recv("d1 p1", 8'h02, 1'b1);
    recv("d1 p2", 8'h03, 1'b1);
    recv("d1 p3", 8'h04, 1'b1);
    recv("d1 crc lo", ~crc[7:0], 1'b1);
    recv("d1 crc hi", ~crc[15:8], 1'b1);
    byte_ready = 1'b1;
    finish_eop("d1");
    chk("d1 fifo_rd count", 32'(rd_count - base), 32'd4);

    // Handshakes with an oversized, ignored tx_size.
    hs_type[0] = 3'd2; hs_pid[0] = 8'hD2;
    hs_type[1] = 3'd3; hs_pid[1] = 8'h5A;
    hs_type[2] = 3'd4; hs_pid[2] = 8'h1E;
    for (int i = 0; i < 3; i++) begin
      base = rd_count;
      start(hs_type[i], SIZE_W'(MAX_PAYLOAD + 5));
      recv($sformatf("hs%0d sync", i), 8'h80, 1'b0);
      recv($sformatf("hs%0d pid", i), hs_pid[i], 1'b0);
      chk($sformatf("hs%0d eop cyc3", i), eop_req, 1'b1);
      finish_eop($sformatf("hs%0d", i));
      chk($sformatf("hs%0d no fifo_rd", i), 32'(rd_count - base), 32'd0);
    end

    // Illegal requests.
    start(3'd6, '0);
    chk("ill type err", tx_error, 1'b1);
    chk("ill type busy", tx_busy, 1'b0);
    chk("ill type valid", byte_valid, 1'b0);
    step();
    chk("ill type err pulse", tx_error, 1'b0);
    start(3'd0, SIZE_W'(MAX_PAYLOAD + 1));
    chk("ill size err", tx_error, 1'b1);
    chk("ill size busy", tx_busy, 1'b0);
    chk("ill size valid", byte_valid, 1'b0);
    step();
    chk("ill size err pulse", tx_error, 1'b0);
    chk("ill size still idle", tx_busy, 1'b0);

    // Underrun: size 3, only 2 bytes available.
    base = rd_count;
    push(8'hAA); push(8'h55);
    start(3'd0, SIZE_W'(3));
    recv("ur sync", 8'h80, 1'b0);
    recv("ur pid", 8'hC3, 1'b0);
    recv("ur p0", 8'hAA, 1'b0);
    recv("ur p1", 8'h55, 1'b0);
    chk("ur err", tx_error, 1'b1);
    chk("ur valid drop", byte_valid, 1'b0);
    chk("ur eop", eop_req, 1'b1);
    step();
    chk("ur err pulse", tx_error, 1'b0);
    finish_eop("ur");
    chk("ur fifo_rd count", 32'(rd_count - base), 32'd2);

    // Mid-packet tx_start is ignored; reset in DATA aborts.
    push(8'h11); push(8'h22); push(8'h33); push(8'h44);
    start(3'd0, SIZE_W'(4));
    recv("rs sync", 8'h80, 1'b0);
    recv("rs pid", 8'hC3, 1'b0);
    tx_start = 1'b1;
    tx_type  = 3'd2;
    tx_size  = '0;
    recv("rs p0", 8'h11, 1'b0);
    tx_start = 1'b0;
    chk("rs no err", tx_error, 1'b0);
    recv("rs p1", 8'h22, 1'b0);
    chk("rs busy", tx_busy, 1'b1);
    rst = 1'b1;
    #1;
    chk_all_zero("rs async");
    step();
    step();
    rst = 1'b0;
    wr_ptr = rd_ptr;
    step();
    base = rd_count;
    push(8'h5A); push(8'hA5);
    crc = crc_model(32'h0000A55A, 2);
    start(3'd1, SIZE_W'(2));
    recv("rs2 sync", 8'h80, 1'b0);
    recv("rs2 pid", 8'h4B, 1'b0);
    recv("rs2 p0", 8'h5A, 1'b0);
    recv("rs2 p1", 8'hA5, 1'b0);
    recv("rs2 crc lo", ~crc[7:0], 1'b0);
    recv("rs2 crc hi", ~crc[15:8], 1'b0);
    finish_eop("rs2");
    chk("rs2 fifo_rd count", 32'(rd_count - base), 32'd2);
    chk("fifo_rd while empty", 32'(rd_empty_count), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
